// File: rtl/vga_frame_fetch_if.sv
// AXI4 read-address and read-data channel bundle used between the frame fetcher and DDR.
// The master modport is the fetcher side. The slave modport is the memory side.
interface vga_frame_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );
endinterface

// File: rtl/vga_frame_fetch.sv
// AXI4 read master that streams one frame from DDR into a first-word fall-through FIFO.
// Only one burst is outstanding at a time, and a burst is issued only when the FIFO has room for all of it.
module vga_frame_fetch #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int BURST_LEN          = 16,
  parameter int FRAME_WORDS        = 76800,
  parameter int FIFO_DEPTH         = 64
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          frame_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] frame_base,
  vga_frame_fetch_if.master             axi,
  output logic [C_M_AXI_DATA_WIDTH-1:0] pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          busy,
  output logic                          err,
  output logic                          underflow
);

  localparam int NUM_BURSTS = FRAME_WORDS / BURST_LEN;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int BEAT_W     = $clog2(BURST_LEN);
  localparam int BCNT_W     = $clog2(NUM_BURSTS + 1);

  localparam logic [CNT_W-1:0]              ISSUE_MAX   = CNT_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [BEAT_W-1:0]             LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [BCNT_W-1:0]             LAST_BURST  = BCNT_W'(NUM_BURSTS - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES = C_M_AXI_ADDR_WIDTH'(BURST_LEN * 4);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_SPACE = 2'd1,
    S_ADDR       = 2'd2,
    S_DATA       = 2'd3
  } state_t;

  state_t                          state_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic                            arvalid_q;
  logic                            rready_q;
  logic                            busy_q;
  logic                            err_q;
  logic                            underflow_q;
  logic [BEAT_W-1:0]               beat_q;
  logic [BCNT_W-1:0]               burst_q;

  logic [C_M_AXI_DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]                wr_ptr_q;
  logic [PTR_W-1:0]                rd_ptr_q;
  logic [CNT_W-1:0]                fifo_cnt_q;
  logic [CNT_W-1:0]                fifo_cnt_d;

  logic                            push_s;
  logic                            pop_s;
  logic                            fifo_nempty_s;

  assign fifo_nempty_s = (fifo_cnt_q != {CNT_W{1'b0}});
  assign push_s        = (state_q == S_DATA) && rready_q && axi.m_axi_rvalid;
  assign pop_s         = fifo_nempty_s && pix_ready;

  // Burst sequencing, protocol checks and all registered status outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      addr_q      <= {C_M_AXI_ADDR_WIDTH{1'b0}};
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      underflow_q <= 1'b0;
      beat_q      <= {BEAT_W{1'b0}};
      burst_q     <= {BCNT_W{1'b0}};
    end else begin
      underflow_q <= busy_q && pix_ready && !fifo_nempty_s;
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            addr_q  <= frame_base;
            burst_q <= {BCNT_W{1'b0}};
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT_SPACE;
          end
        end
        S_WAIT_SPACE: begin
          // Room for a whole burst means the data phase never needs to stall
          if (fifo_cnt_q <= ISSUE_MAX) begin
            arvalid_q <= 1'b1;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (axi.m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= {BEAT_W{1'b0}};
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (push_s) begin
            if (axi.m_axi_rresp != 2'b00) begin
              err_q <= 1'b1;
            end
            if (beat_q == LAST_BEAT) begin
              // The beat count alone ends the burst. A missing rlast is only flagged.
              if (!axi.m_axi_rlast) begin
                err_q <= 1'b1;
              end
              rready_q <= 1'b0;
              beat_q   <= {BEAT_W{1'b0}};
              addr_q   <= addr_q + BURST_BYTES;
              burst_q  <= burst_q + BCNT_W'(1);
              if (burst_q == LAST_BURST) begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_WAIT_SPACE;
              end
            end else begin
              if (axi.m_axi_rlast) begin
                err_q <= 1'b1;
              end
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // FIFO occupancy after this cycle's push and pop
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      fifo_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // FIFO storage; the contents do not need a reset because the occupancy count qualifies them
  always_ff @(posedge ACLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= axi.m_axi_rdata;
    end
  end

  assign axi.m_axi_araddr  = addr_q;
  assign axi.m_axi_arlen   = 8'(BURST_LEN - 1);
  assign axi.m_axi_arsize  = 3'b010;
  assign axi.m_axi_arburst = 2'b01;
  assign axi.m_axi_arvalid = arvalid_q;
  assign axi.m_axi_rready  = rready_q;

  assign pix_valid = fifo_nempty_s;
  assign pix_data  = fifo_nempty_s ? mem_q[rd_ptr_q] : {C_M_AXI_DATA_WIDTH{1'b0}};
  assign busy      = busy_q;
  assign err       = err_q;
  assign underflow = underflow_q;

endmodule
